// File: rtl/bcd_cascade_ctrl.sv
// Multi-digit BCD counter controller: increment/decrement ripple one digit per
// cycle, single-cycle load (with digit validation) and clear.
`timescale 1ns/1ps
module bcd_cascade_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   cmd_data,
  output logic [4*DIGITS-1:0]   value,
  output logic                  busy,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {IDLE, STEP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  dir_q, dir_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic                  wrap_q, wrap_d;
  logic                  load_err_q, load_err_d;
  logic [3:0]            cur_digit;
  logic                  rolls;

  function automatic logic [3:0] digit_step(input logic [3:0] d, input logic down);
    if (down) return (d == 4'd0) ? 4'd9 : d - 4'd1;
    else      return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic digit_rolls(input logic [3:0] d, input logic down);
    return down ? (d == 4'd0) : (d == 4'd9);
  endfunction

  function automatic logic bcd_legal(input logic [4*DIGITS-1:0] v);
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++)
      if (idx_q == IDX_W'(k)) cur_digit = value_q[4*k +: 4];
  end

  assign rolls = digit_rolls(cur_digit, dir_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    value_d    = value_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_INC: begin
              state_d = STEP;
              idx_d   = '0;
              dir_d   = 1'b0;
            end
            OP_DEC: begin
              state_d = STEP;
              idx_d   = '0;
              dir_d   = 1'b1;
            end
            OP_LOAD: begin
              // Illegal digits are refused outright so value never holds non-BCD.
              if (bcd_legal(cmd_data)) value_d = cmd_data;
              else                     load_err_d = 1'b1;
            end
            default: value_d = '0;
          endcase
        end
      end
      STEP: begin
        for (int k = 0; k < DIGITS; k++)
          if (idx_q == IDX_W'(k)) value_d[4*k +: 4] = digit_step(cur_digit, dir_q);
        if (rolls && (idx_q != LAST_IDX)) begin
          idx_d = idx_q + 1'b1;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          wrap_d  = rolls;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dir_q      <= 1'b0;
      value_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == STEP);
  assign value     = value_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Bench for bcd_cascade_ctrl (DIGITS=4): vector table with a scoreboard queue,
// plus hand-written back-to-back, reset-abort and held-command sequences.
`timescale 1ns/1ps
module tb_bcd_cascade_ctrl;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;
  localparam int NREC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] value;
  logic        busy;
  logic        wrap;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] exp_val;
    int          exp_lat;
    int          exp_wrap;
    int          exp_err;
  } rec_t;

  rec_t tbl [NREC];
  rec_t sb [$];

  bcd_cascade_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .value(value), .busy(busy),
    .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one command and observes it to completion.
  task automatic run_rec(input int i, input rec_t r);
    rec_t e;
    int n, lat, wr, er;
    bit done;
    cmd_valid = 1'b1;
    cmd_op    = r.op;
    cmd_data  = r.data;
    sb.push_back(r);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("rec%0d_accept_timeout", i), 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; lat = 0; wr = 0; er = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      wr += int'(wrap);
      er += int'(load_err);
      if (busy) lat++;
      else      done = 1'b1;
    end
    chk($sformatf("rec%0d_ripple_timeout", i), 32'(done), 32'd1);
    @(negedge clk);
    wr += int'(wrap);
    er += int'(load_err);
    e = sb.pop_front();
    chk($sformatf("rec%0d_value", i), 32'(value), 32'(e.exp_val));
    chk($sformatf("rec%0d_latency", i), 32'(lat), 32'(e.exp_lat));
    chk($sformatf("rec%0d_wrap", i), 32'(wr), 32'(e.exp_wrap));
    chk($sformatf("rec%0d_load_err", i), 32'(er), 32'(e.exp_err));
    chk($sformatf("rec%0d_ready", i), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n, acc, gap;
    tbl[0]  = '{OP_CLR,  16'h0000, 16'h0000, 0, 0, 0};
    tbl[1]  = '{OP_INC,  16'h0000, 16'h0001, 1, 0, 0};
    tbl[2]  = '{OP_LOAD, 16'h0999, 16'h0999, 0, 0, 0};
    tbl[3]  = '{OP_INC,  16'h0000, 16'h1000, 4, 0, 0};
    tbl[4]  = '{OP_LOAD, 16'h9999, 16'h9999, 0, 0, 0};
    tbl[5]  = '{OP_INC,  16'h0000, 16'h0000, 4, 1, 0};
    tbl[6]  = '{OP_DEC,  16'h0000, 16'h9999, 4, 1, 0};
    tbl[7]  = '{OP_LOAD, 16'h12A4, 16'h9999, 0, 0, 1};
    tbl[8]  = '{OP_LOAD, 16'h1234, 16'h1234, 0, 0, 0};
    tbl[9]  = '{OP_CLR,  16'h0000, 16'h0000, 0, 0, 0};
    tbl[10] = '{OP_LOAD, 16'h1000, 16'h1000, 0, 0, 0};
    tbl[11] = '{OP_DEC,  16'h0000, 16'h0999, 4, 0, 0};
    tbl[12] = '{OP_LOAD, 16'h0050, 16'h0050, 0, 0, 0};
    tbl[13] = '{OP_DEC,  16'h0000, 16'h0049, 2, 0, 0};
    tbl[14] = '{OP_LOAD, 16'hF000, 16'h0049, 0, 0, 1};
    tbl[15] = '{OP_INC,  16'h0000, 16'h0050, 2, 0, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_INC; cmd_data = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NREC; i++) run_rec(i, tbl[i]);

    // Back-to-back: rejected load, good load, clear on consecutive cycles.
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 16'h12A4;
    @(negedge clk);
    chk("b2b_err_pulse", 32'(load_err), 32'd1);
    chk("b2b_value_kept", 32'(value), 32'h0050);
    chk("b2b_ready", 32'(cmd_ready), 32'd1);
    cmd_data = 16'h1234;
    @(negedge clk);
    chk("b2b_load", 32'(value), 32'h1234);
    chk("b2b_err_clear", 32'(load_err), 32'd0);
    cmd_op = OP_CLR;
    @(negedge clk);
    chk("b2b_clear", 32'(value), 32'h0000);
    cmd_valid = 1'b0;

    // Reset at the second STEP edge of a 0999 increment, with a load presented.
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 16'h0999;
    @(negedge clk);
    cmd_op = OP_INC;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_partial", 32'(value), 32'h0990);
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 16'h1234;
    @(negedge clk);
    chk("abort_value", 32'(value), 32'h0000);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_wrap", 32'(wrap), 32'd0);
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_wrap_after", 32'(wrap), 32'd0);
    chk("abort_value_after", 32'(value), 32'h0000);

    // Increment held valid through a ripple: second acceptance only once idle.
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 16'h0999;
    @(negedge clk);
    cmd_op = OP_INC;
    acc = 0; gap = 0; n = 0;
    while (acc < 2 && n < 40) begin
      if (cmd_ready) acc++;
      if (acc == 2) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end else begin
        @(negedge clk);
        n++;
        if (acc == 1) gap++;
      end
    end
    chk("hold_accepts", 32'(acc), 32'd2);
    chk("hold_gap", 32'(gap), 32'd5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    chk("hold_idle_timeout", 32'(n < 20), 32'd1);
    chk("hold_value", 32'(value), 32'h1001);
    repeat (3) @(negedge clk);
    chk("hold_value_stable", 32'(value), 32'h1001);
    chk("hold_ready", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
